// File: rtl/ai_pkg.sv
// Shared definitions for the AI register block: bus master FSM states,
// command/location field layout and default slave register map.
package ai_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ENEMY,
    ST_RD_PLAYER,
    ST_CALC,
    ST_WR_CMD
  } ai_mst_state_t;

  localparam int CMD_LEFT  = 0;
  localparam int CMD_RIGHT = 1;
  localparam int CMD_UP    = 2;
  localparam int CMD_DOWN  = 3;

  localparam int LOC_X_MSB = 15;
  localparam int LOC_X_LSB = 8;
  localparam int LOC_Y_MSB = 7;
  localparam int LOC_Y_LSB = 0;

  localparam logic [3:0] AI_ADDR_CMD    = 4'd0;
  localparam logic [3:0] AI_ADDR_ENEMY  = 4'd1;
  localparam logic [3:0] AI_ADDR_PLAYER = 4'd2;

endpackage

// File: rtl/ai_chase_calc.sv
// Chase direction from enemy/player locations; compares are 9-bit so the
// deadzone offset can never wrap past the edge of the 8-bit coordinate.
module ai_chase_calc
  import ai_pkg::*;
#(
  parameter int DEADZONE = 2
) (
  input  logic [15:0] enemy_loc,
  input  logic [15:0] player_loc,
  output logic [3:0]  dir
);

  logic [8:0] ex, ey, px, py, dz;

  always_comb begin
    ex  = {1'b0, enemy_loc[LOC_X_MSB:LOC_X_LSB]};
    ey  = {1'b0, enemy_loc[LOC_Y_MSB:LOC_Y_LSB]};
    px  = {1'b0, player_loc[LOC_X_MSB:LOC_X_LSB]};
    py  = {1'b0, player_loc[LOC_Y_MSB:LOC_Y_LSB]};
    dz  = 9'(DEADZONE);
    dir = '0;
    dir[CMD_RIGHT] = px > ex + dz;
    dir[CMD_LEFT]  = px + dz < ex;
    dir[CMD_DOWN]  = py > ey + dz;
    dir[CMD_UP]    = py + dz < ey;
  end

endmodule

// File: rtl/ai_avalon_master.sv
// Frame-driven Avalon-MM master: read enemy, read player, write a chase
// command to the AI register slave once per TICK.
module ai_avalon_master
  import ai_pkg::*;
#(
  parameter int         DEADZONE    = 2,
  parameter int         TIMEOUT     = 15,
  parameter logic [3:0] ADDR_CMD    = AI_ADDR_CMD,
  parameter logic [3:0] ADDR_ENEMY  = AI_ADDR_ENEMY,
  parameter logic [3:0] ADDR_PLAYER = AI_ADDR_PLAYER
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TICK,
  output logic        M_READ,
  output logic        M_WRITE,
  output logic        M_CS,
  output logic [1:0]  M_BYTE_EN,
  output logic [3:0]  M_ADDR,
  output logic [15:0] M_WRITEDATA,
  input  logic [15:0] M_READDATA,
  input  logic        M_WAITREQUEST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] LAST_CMD
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ai_mst_state_t  state_q, state_d;
  logic           pending_q;
  logic [7:0]     seq_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [15:0]    enemy_q, player_q, cmd_q;
  logic [3:0]     dir;

  logic bus_st, stall, timeout;
  logic cap_enemy, cap_player, load_cmd, wr_done, abort;

  ai_chase_calc #(.DEADZONE(DEADZONE)) u_calc (
    .enemy_loc  (enemy_q),
    .player_loc (player_q),
    .dir        (dir)
  );

  always_comb begin
    state_d    = state_q;
    cap_enemy  = 1'b0;
    cap_player = 1'b0;
    load_cmd   = 1'b0;
    wr_done    = 1'b0;
    abort      = 1'b0;
    bus_st     = (state_q == ST_RD_ENEMY) || (state_q == ST_RD_PLAYER) ||
                 (state_q == ST_WR_CMD);
    stall      = bus_st && M_WAITREQUEST;
    timeout    = stall && (wait_cnt_q == WCW'(TIMEOUT - 1));
    case (state_q)
      ST_IDLE:      if (TICK || pending_q) state_d = ST_RD_ENEMY;
      ST_RD_ENEMY: begin
        if (timeout) begin
          abort = 1'b1; state_d = ST_IDLE;
        end else if (!M_WAITREQUEST) begin
          cap_enemy = 1'b1; state_d = ST_RD_PLAYER;
        end
      end
      ST_RD_PLAYER: begin
        if (timeout) begin
          abort = 1'b1; state_d = ST_IDLE;
        end else if (!M_WAITREQUEST) begin
          cap_player = 1'b1; state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        load_cmd = 1'b1; state_d = ST_WR_CMD;
      end
      ST_WR_CMD: begin
        if (timeout) begin
          abort = 1'b1; state_d = ST_IDLE;
        end else if (!M_WAITREQUEST) begin
          wr_done = 1'b1; state_d = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      seq_q      <= '0;
      wait_cnt_q <= '0;
      enemy_q    <= '0;
      player_q   <= '0;
      cmd_q      <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      LAST_CMD   <= '0;
    end else begin
      state_q    <= state_d;
      // A tick arriving while busy (including the final busy cycle) is
      // remembered once; IDLE always consumes or ignores it.
      if (state_q == ST_IDLE) pending_q <= 1'b0;
      else if (TICK)          pending_q <= 1'b1;
      wait_cnt_q <= (stall && !timeout) ? wait_cnt_q + 1'b1 : '0;
      if (cap_enemy)  enemy_q  <= M_READDATA;
      if (cap_player) player_q <= M_READDATA;
      if (load_cmd)   cmd_q    <= {seq_q + 8'd1, 4'b0000, dir};
      if (wr_done) begin
        seq_q    <= seq_q + 8'd1;
        LAST_CMD <= cmd_q;
      end
      DONE <= wr_done;
      if (abort) ERR <= 1'b1;
    end
  end

  always_comb begin
    M_READ      = (state_q == ST_RD_ENEMY) || (state_q == ST_RD_PLAYER);
    M_WRITE     = (state_q == ST_WR_CMD);
    M_CS        = M_READ || M_WRITE;
    M_BYTE_EN   = M_CS ? 2'b11 : 2'b00;
    M_WRITEDATA = M_WRITE ? cmd_q : 16'h0000;
    BUSY        = (state_q != ST_IDLE);
    case (state_q)
      ST_RD_ENEMY:  M_ADDR = ADDR_ENEMY;
      ST_RD_PLAYER: M_ADDR = ADDR_PLAYER;
      ST_WR_CMD:    M_ADDR = ADDR_CMD;
      default:      M_ADDR = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_ai_avalon_master.sv
// Directed bench for ai_avalon_master: table of location pairs plus
// hand sequences for stalls, timeout, tick queuing, reset and seq wrap.
module tb_ai_avalon_master;

  logic        CLK = 1'b0;
  logic        RESET, TICK;
  logic        M_READ, M_WRITE, M_CS;
  logic [1:0]  M_BYTE_EN;
  logic [3:0]  M_ADDR;
  logic [15:0] M_WRITEDATA, M_READDATA;
  logic        M_WAITREQUEST;
  logic        BUSY, DONE, ERR;
  logic [15:0] LAST_CMD;

  logic [15:0] sl_enemy, sl_player;
  int          n_chk = 0, n_err = 0;
  int          wr_cnt = 0, done_cnt = 0;
  logic [15:0] last_wd = '0;
  logic [7:0]  exp_seq;
  logic [15:0] exp_last;

  always #5 CLK = ~CLK;

  ai_avalon_master dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_CS(M_CS), .M_BYTE_EN(M_BYTE_EN),
    .M_ADDR(M_ADDR), .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA),
    .M_WAITREQUEST(M_WAITREQUEST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .LAST_CMD(LAST_CMD)
  );

  // Slave register file model
  assign M_READDATA = (M_ADDR == 4'd1) ? sl_enemy :
                      (M_ADDR == 4'd2) ? sl_player : 16'hBEEF;

  always @(posedge CLK) begin
    if (!RESET && M_WRITE && !M_WAITREQUEST) begin
      wr_cnt  <= wr_cnt + 1;
      last_wd <= M_WRITEDATA;
    end
    if (DONE) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [15:0] enemy;
    logic [15:0] player;
    logic [3:0]  dir;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET = 1'b1; TICK = 1'b0; M_WAITREQUEST = 1'b0;
    @(negedge CLK); @(negedge CLK); RESET = 1'b0;
    exp_seq = 8'd0; exp_last = 16'h0000;
  endtask

  // Full no-stall sequence with per-cycle bus checks; TICK sampled at edge 0.
  task automatic run_vec(input logic [15:0] e, input logic [15:0] p, input logic [3:0] d);
    logic [15:0] exp;
    sl_enemy = e; sl_player = p;
    exp_seq = exp_seq + 8'd1;
    exp = {exp_seq, 4'h0, d};
    @(negedge CLK); TICK = 1'b1;
    @(negedge CLK); TICK = 1'b0;
    chk("c1_read", {M_READ, M_WRITE, M_CS, BUSY}, 4'b1011);
    chk("c1_addr", M_ADDR, 4'd1);
    @(negedge CLK);
    chk("c2_read", {M_READ, M_WRITE, M_CS, BUSY}, 4'b1011);
    chk("c2_addr", M_ADDR, 4'd2);
    @(negedge CLK);
    chk("c3_calc", {M_READ, M_WRITE, M_CS, BUSY, M_BYTE_EN}, 6'b000100);
    @(negedge CLK);
    chk("c4_write", {M_READ, M_WRITE, M_CS, BUSY, DONE, M_BYTE_EN}, 7'b0111011);
    chk("c4_addr", M_ADDR, 4'd0);
    chk("c4_wdata", M_WRITEDATA, exp);
    @(negedge CLK);
    chk("c5_done", {DONE, BUSY, M_CS}, 3'b100);
    chk("c5_last", LAST_CMD, exp);
    chk("c5_wdata_idle", M_WRITEDATA, 16'h0000);
    exp_last = exp;
  endtask

  initial begin
    int w0, d0, cnt, guard;
    logic ok;
    RESET = 1'b1; TICK = 1'b0; M_WAITREQUEST = 1'b0;
    sl_enemy = '0; sl_player = '0;
    vecs[0]  = '{16'h1020, 16'h3010, 4'h6};
    vecs[1]  = '{16'h4040, 16'h4142, 4'h0};
    vecs[2]  = '{16'h5050, 16'h4D53, 4'h9};
    vecs[3]  = '{16'h00FF, 16'hFF00, 4'h6};
    vecs[4]  = '{16'hFF00, 16'h00FF, 4'h9};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 4'h0};
    vecs[6]  = '{16'h4040, 16'h4340, 4'h2};
    vecs[7]  = '{16'h4040, 16'h3D40, 4'h1};
    vecs[8]  = '{16'h4040, 16'h3E40, 4'h0};
    vecs[9]  = '{16'h4040, 16'h4043, 4'h8};
    vecs[10] = '{16'h4040, 16'h403D, 4'h4};

    do_reset();
    chk("rst_bus", {M_READ, M_WRITE, M_CS, M_BYTE_EN, M_ADDR}, 9'h0);
    chk("rst_flags", {BUSY, DONE, ERR}, 3'b000);
    chk("rst_wdata", M_WRITEDATA, 16'h0);
    chk("rst_last", LAST_CMD, 16'h0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i].enemy, vecs[i].player, vecs[i].dir);

    // Five stall cycles in RD_PLAYER; player data only valid on the completing edge.
    sl_enemy = 16'h1020; sl_player = 16'h0000;
    @(negedge CLK); TICK = 1'b1;
    @(negedge CLK); TICK = 1'b0;
    @(negedge CLK); M_WAITREQUEST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bus", {M_READ, M_WRITE, M_CS, M_BYTE_EN, BUSY}, 6'b101111);
      chk("stall_addr", M_ADDR, 4'd2);
      @(negedge CLK);
      if (i == 4) begin M_WAITREQUEST = 1'b0; sl_player = 16'h3010; end
    end
    chk("stall_last_rd", {M_READ, M_ADDR}, 5'b10010);
    @(negedge CLK);
    chk("stall_calc", {M_READ, M_WRITE, BUSY}, 3'b001);
    @(negedge CLK);
    exp_seq = exp_seq + 8'd1;
    chk("stall_wdata", M_WRITEDATA, {exp_seq, 8'h06});
    @(negedge CLK);
    chk("stall_done", {DONE, ERR}, 2'b10);
    exp_last = {exp_seq, 8'h06};

    // Three extra ticks during one busy sequence queue exactly one rerun.
    w0 = wr_cnt;
    @(negedge CLK); TICK = 1'b1;
    repeat (4) @(negedge CLK);
    TICK = 1'b0;
    repeat (30) @(negedge CLK);
    chk("queue_writes", wr_cnt - w0, 2);
    exp_seq = exp_seq + 8'd2;
    exp_last = {exp_seq, 8'h06};
    chk("queue_last", LAST_CMD, exp_last);
    chk("queue_idle", BUSY, 1'b0);

    // Stuck WAITREQUEST in WR_CMD aborts after TIMEOUT stall cycles.
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge CLK); TICK = 1'b1;
    @(negedge CLK); TICK = 1'b0;
    repeat (2) @(negedge CLK);
    M_WAITREQUEST = 1'b1;
    @(negedge CLK);
    cnt = 0; guard = 0;
    while (M_WRITE && guard < 40) begin
      cnt++; guard++;
      @(negedge CLK);
    end
    chk("tmo_cycles", cnt, 15);
    chk("tmo_err_idle", {ERR, BUSY, DONE}, 3'b100);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_no_write", wr_cnt - w0, 0);
    chk("tmo_last", LAST_CMD, exp_last);
    M_WAITREQUEST = 1'b0;
    run_vec(16'h1020, 16'h3010, 4'h6);
    chk("tmo_err_sticky", ERR, 1'b1);

    // Reset during RD_PLAYER drops everything.
    sl_enemy = 16'h1020; sl_player = 16'h3010;
    w0 = wr_cnt;
    @(negedge CLK); TICK = 1'b1;
    @(negedge CLK); TICK = 1'b0;
    @(negedge CLK);
    chk("rstmid_pre", {M_READ, M_ADDR}, 5'b10010);
    RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    chk("rstmid_bus", {M_READ, M_WRITE, BUSY, ERR, DONE}, 5'b00000);
    chk("rstmid_last", LAST_CMD, 16'h0);
    repeat (10) @(negedge CLK);
    chk("rstmid_no_write", wr_cnt - w0, 0);
    exp_seq = 8'd0;

    // 256 centred sequences: seq wraps so the last write is 0x0000.
    sl_enemy = 16'h4040; sl_player = 16'h4142;
    for (int i = 1; i <= 256; i++) begin
      @(negedge CLK); TICK = 1'b1;
      @(negedge CLK); TICK = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge CLK);
        if (DONE) ok = 1'b1;
      end
      chk("wrap_done_seen", ok, 1'b1);
      exp_seq = exp_seq + 8'd1;
      chk("wrap_wdata", last_wd, {exp_seq, 8'h00});
    end
    chk("wrap_final", LAST_CMD, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
